uart_baud_tick_gen: RTL and testbench

//   Parametrised fractional baud-rate generator for the UART TX/RX paths.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_frac_divider.sv | 120 ++++++++++++
 rtl/uart_baud_tick_gen.sv | 82 ++++++++
 tb/tb_uart_baud_tick_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and divisor type for the UART baud-rate generator.
// Default widths and the post-reset divisor are collected here.
package uart_pkg;

    localparam int UART_DIV_W        = 16;
    localparam int UART_FRAC_W       = 4;
    localparam int UART_OVS          = 16;
    localparam int UART_DIV_RST_INT  = 27;
    localparam int UART_DIV_RST_FRAC = 2;

    typedef struct packed {
        logic [UART_DIV_W-1:0]  int_part;
        logic [UART_FRAC_W-1:0] frac_part;
    } baud_div_t;

    localparam baud_div_t UART_DIV_DEFAULT = '{
        int_part:  UART_DIV_W'(UART_DIV_RST_INT),
        frac_part: UART_FRAC_W'(UART_DIV_RST_FRAC)
    };

endpackage

// File: rtl/uart_frac_divider.sv
// Fractional clock divider: period counter plus phase accumulator producing the
// oversample tick, with double-buffered divisor so reloads never cut a period short.
module uart_frac_divider
    import uart_pkg::*;
#(
    parameter int DIV_W        = UART_DIV_W,
    parameter int FRAC_W       = UART_FRAC_W,
    parameter int DIV_RST_INT  = UART_DIV_RST_INT,
    parameter int DIV_RST_FRAC = UART_DIV_RST_FRAC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    input  logic              div_load_i,
    input  logic              sync_clear_i,
    output logic              tick_ovs_o,
    output logic              period_end_o
);

    typedef struct packed {
        logic [DIV_W-1:0]  int_part;
        logic [FRAC_W-1:0] frac_part;
    } div_pair_t;

    localparam div_pair_t DIV_RESET = '{
        int_part:  DIV_W'(DIV_RST_INT),
        frac_part: FRAC_W'(DIV_RST_FRAC)
    };

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    div_pair_t         active_q, active_d;
    div_pair_t         pend_q, pend_d;
    logic              pending_q, pending_d;
    logic              tick_q, tick_d;

    div_pair_t         load_val;
    logic [DIV_W-1:0]  eff_int;
    logic [FRAC_W:0]   acc_sum;
    logic              carry;
    logic [DIV_W-1:0]  last_cnt;
    logic              at_last;

    // The carry of this period's accumulator step stretches the period by one clock.
    always_comb begin
        load_val = '{int_part: div_int_i, frac_part: div_frac_i};
        eff_int  = (active_q.int_part == '0) ? DIV_W'(1) : active_q.int_part;
        acc_sum  = {1'b0, acc_q} + {1'b0, active_q.frac_part};
        carry    = acc_sum[FRAC_W];
        last_cnt = eff_int - DIV_W'(1) + DIV_W'(carry);
        at_last  = (cnt_q >= last_cnt);
    end

    assign period_end_o = enable_i && !sync_clear_i && at_last;

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        active_d  = active_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        tick_d    = 1'b0;

        if (sync_clear_i) begin
            cnt_d     = '0;
            acc_d     = '0;
            pending_d = 1'b0;
            if (div_load_i) begin
                active_d = load_val;
            end else if (pending_q) begin
                active_d = pend_q;
            end
        end else if (!enable_i) begin
            // While idle there is no running period to protect, so a load takes effect at once.
            if (div_load_i) begin
                active_d  = load_val;
                pending_d = 1'b0;
            end
        end else if (at_last) begin
            cnt_d     = '0;
            acc_d     = acc_sum[FRAC_W-1:0];
            tick_d    = 1'b1;
            pending_d = 1'b0;
            if (div_load_i) begin
                active_d = load_val;
            end else if (pending_q) begin
                active_d = pend_q;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
            if (div_load_i) begin
                pend_d    = load_val;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            active_q  <= DIV_RESET;
            pend_q    <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
        end
    end

    assign tick_ovs_o = tick_q;

endmodule

// File: rtl/uart_baud_tick_gen.sv
// Baud tick generator: fractional oversample divider followed by a divide-by-OVS
// phase counter that marks bit boundaries and mid-bit sample points.
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W        = UART_DIV_W,
    parameter int FRAC_W       = UART_FRAC_W,
    parameter int OVS          = UART_OVS,
    parameter int DIV_RST_INT  = UART_DIV_RST_INT,
    parameter int DIV_RST_FRAC = UART_DIV_RST_FRAC
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    div_load,
    input  logic                    sync_clear,
    output logic                    tick_ovs,
    output logic                    tick_mid,
    output logic                    tick_bit,
    output logic [$clog2(OVS)-1:0]  ovs_phase
);

    localparam int PH_W = $clog2(OVS);

    logic            period_end;
    logic [PH_W-1:0] ovs_cnt_q, ovs_cnt_d;
    logic [PH_W-1:0] ovs_next;
    logic            tick_bit_q, tick_bit_d;
    logic            tick_mid_q, tick_mid_d;

    uart_frac_divider #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .DIV_RST_INT  (DIV_RST_INT),
        .DIV_RST_FRAC (DIV_RST_FRAC)
    ) u_frac_divider (
        .clock        (clock),
        .reset        (reset),
        .enable_i     (enable),
        .div_int_i    (div_int),
        .div_frac_i   (div_frac),
        .div_load_i   (div_load),
        .sync_clear_i (sync_clear),
        .tick_ovs_o   (tick_ovs),
        .period_end_o (period_end)
    );

    // Bit and mid ticks are decoded from the phase the counter is about to enter,
    // so they line up with the oversample tick registered on the same edge.
    always_comb begin
        ovs_next   = (ovs_cnt_q == PH_W'(OVS - 1)) ? '0 : ovs_cnt_q + PH_W'(1);
        ovs_cnt_d  = ovs_cnt_q;
        tick_bit_d = 1'b0;
        tick_mid_d = 1'b0;
        if (sync_clear) begin
            ovs_cnt_d = '0;
        end else if (period_end) begin
            ovs_cnt_d  = ovs_next;
            tick_bit_d = (ovs_next == PH_W'(OVS - 1));
            tick_mid_d = (ovs_next == PH_W'(OVS / 2 - 1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovs_cnt_q  <= '0;
            tick_bit_q <= 1'b0;
            tick_mid_q <= 1'b0;
        end else begin
            ovs_cnt_q  <= ovs_cnt_d;
            tick_bit_q <= tick_bit_d;
            tick_mid_q <= tick_mid_d;
        end
    end

    assign ovs_phase = ovs_cnt_q;
    assign tick_bit  = tick_bit_q;
    assign tick_mid  = tick_mid_q;

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Directed testbench for uart_baud_tick_gen with hand-derived tick positions.
module tb_uart_baud_tick_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        sync_clear;
    logic        tick_ovs;
    logic        tick_mid;
    logic        tick_bit;
    logic [3:0]  ovs_phase;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_baud_tick_gen #(
        .DIV_W        (16),
        .FRAC_W       (4),
        .OVS          (16),
        .DIV_RST_INT  (27),
        .DIV_RST_FRAC (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .div_load   (div_load),
        .sync_clear (sync_clear),
        .tick_ovs   (tick_ovs),
        .tick_mid   (tick_mid),
        .tick_bit   (tick_bit),
        .ovs_phase  (ovs_phase)
    );

    // Drive one cycle of inputs, then sample just after the edge that consumes them.
    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] di,
                                 input logic [3:0] df, input logic sc);
        enable     = en;
        div_load   = ld;
        div_int    = di;
        div_frac   = df;
        sync_clear = sc;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic exp;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
        reset = 1'b0;
        checks++; if (tick_ovs !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick_ovs got %b want 0", tick_ovs); end
        checks++; if (tick_mid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick_mid got %b want 0", tick_mid); end
        checks++; if (tick_bit !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick_bit got %b want 0", tick_bit); end
        checks++; if (ovs_phase !== 4'd0) begin errors++; $display("[TB] FAIL reset_phase got %0d want 0", ovs_phase); end
        // Default divisor 27 + 2/16: first period is 27 clocks.
        for (int k = 1; k <= 27; k++) begin
            applyStimulus(1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
            exp = (k == 27);
            checks++;
            if (tick_ovs !== exp) begin errors++; $display("[TB] FAIL reset_default_tick step %0d got %b want %b", k, tick_ovs, exp); end
        end
    endtask

    task automatic test_integer_div();
        int t;
        logic expOvs, expMid, expBit;
        logic [3:0] expPh;
        do_reset();
        applyStimulus(1'b0, 1'b1, 16'd4, 4'd0, 1'b0);
        for (int k = 1; k <= 140; k++) begin
            applyStimulus(1'b1, 1'b0, 16'd4, 4'd0, 1'b0);
            t      = k / 4;
            expOvs = (k % 4 == 0);
            expMid = expOvs && (t % 16 == 7);
            expBit = expOvs && (t % 16 == 15);
            expPh  = 4'(t % 16);
            checks++; if (tick_ovs !== expOvs) begin errors++; $display("[TB] FAIL int_tick_ovs step %0d got %b want %b", k, tick_ovs, expOvs); end
            checks++; if (tick_mid !== expMid) begin errors++; $display("[TB] FAIL int_tick_mid step %0d got %b want %b", k, tick_mid, expMid); end
            checks++; if (tick_bit !== expBit) begin errors++; $display("[TB] FAIL int_tick_bit step %0d got %b want %b", k, tick_bit, expBit); end
            checks++; if (ovs_phase !== expPh) begin errors++; $display("[TB] FAIL int_phase step %0d got %0d want %0d", k, ovs_phase, expPh); end
        end
    endtask

    task automatic test_fractional_div();
        int nextTick = 4;
        int idx = 0;
        int seen = 0;
        logic exp;
        do_reset();
        applyStimulus(1'b0, 1'b1, 16'd4, 4'd8, 1'b0);
        for (int k = 1; k <= 72; k++) begin
            applyStimulus(1'b1, 1'b0, 16'd4, 4'd8, 1'b0);
            exp = (k == nextTick);
            if (exp) begin
                idx++;
                nextTick += (idx % 2 == 1) ? 5 : 4;
            end
            if (tick_ovs === 1'b1) seen++;
            checks++;
            if (tick_ovs !== exp) begin errors++; $display("[TB] FAIL frac_tick step %0d got %b want %b", k, tick_ovs, exp); end
        end
        checks++; if (seen != 16) begin errors++; $display("[TB] FAIL frac_count got %0d want 16", seen); end
        checks++; if (ovs_phase !== 4'd0) begin errors++; $display("[TB] FAIL frac_phase got %0d want 0", ovs_phase); end
    endtask

    task automatic test_min_divisor();
        logic expBit;
        logic [3:0] expPh;
        for (int d = 0; d <= 1; d++) begin
            do_reset();
            applyStimulus(1'b0, 1'b1, 16'(d), 4'd0, 1'b0);
            for (int k = 1; k <= 40; k++) begin
                applyStimulus(1'b1, 1'b0, 16'(d), 4'd0, 1'b0);
                expBit = (k % 16 == 15);
                expPh  = 4'(k % 16);
                checks++; if (tick_ovs !== 1'b1) begin errors++; $display("[TB] FAIL min_tick_ovs div %0d step %0d got %b want 1", d, k, tick_ovs); end
                checks++; if (tick_bit !== expBit) begin errors++; $display("[TB] FAIL min_tick_bit div %0d step %0d got %b want %b", d, k, tick_bit, expBit); end
                checks++; if (ovs_phase !== expPh) begin errors++; $display("[TB] FAIL min_phase div %0d step %0d got %0d want %0d", d, k, ovs_phase, expPh); end
            end
        end
    endtask

    // Loads 7 then 3 while the divisor-10 period runs; only 3 should take effect, after that period.
    task automatic test_reload();
        logic exp;
        logic ld;
        do_reset();
        applyStimulus(1'b0, 1'b1, 16'd10, 4'd0, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            ld = (k == 2) || (k == 3);
            applyStimulus(1'b1, ld, (k == 2) ? 16'd7 : 16'd3, 4'd0, 1'b0);
            exp = (k == 10) || ((k > 10) && ((k - 10) % 3 == 0));
            checks++;
            if (tick_ovs !== exp) begin errors++; $display("[TB] FAIL reload_tick step %0d got %b want %b", k, tick_ovs, exp); end
        end
    endtask

    task automatic test_sync_clear();
        logic exp;
        do_reset();
        applyStimulus(1'b0, 1'b1, 16'd6, 4'd0, 1'b0);
        for (int k = 1; k <= 59; k++) applyStimulus(1'b1, 1'b0, 16'd6, 4'd0, 1'b0);
        checks++; if (ovs_phase !== 4'd9) begin errors++; $display("[TB] FAIL sync_pre_phase got %0d want 9", ovs_phase); end
        // cnt is 5 = P-1 here, so the clear also swallows a tick that was due.
        applyStimulus(1'b1, 1'b0, 16'd6, 4'd0, 1'b1);
        checks++; if (ovs_phase !== 4'd0) begin errors++; $display("[TB] FAIL sync_phase got %0d want 0", ovs_phase); end
        checks++; if (tick_ovs !== 1'b0) begin errors++; $display("[TB] FAIL sync_tick got %b want 0", tick_ovs); end
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 1'b0, 16'd6, 4'd0, 1'b0);
            exp = (k == 6);
            checks++;
            if (tick_ovs !== exp) begin errors++; $display("[TB] FAIL sync_resume_tick step %0d got %b want %b", k, tick_ovs, exp); end
        end
        checks++; if (ovs_phase !== 4'd1) begin errors++; $display("[TB] FAIL sync_resume_phase got %0d want 1", ovs_phase); end
    endtask

    task automatic test_enable_hold();
        logic exp;
        do_reset();
        applyStimulus(1'b0, 1'b1, 16'd5, 4'd0, 1'b0);
        for (int k = 1; k <= 12; k++) applyStimulus(1'b1, 1'b0, 16'd5, 4'd0, 1'b0);
        checks++; if (ovs_phase !== 4'd2) begin errors++; $display("[TB] FAIL hold_pre_phase got %0d want 2", ovs_phase); end
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0, 1'b0, 16'd5, 4'd0, 1'b0);
            checks++; if (tick_ovs !== 1'b0) begin errors++; $display("[TB] FAIL hold_tick step %0d got %b want 0", k, tick_ovs); end
            checks++; if (ovs_phase !== 4'd2) begin errors++; $display("[TB] FAIL hold_phase step %0d got %0d want 2", k, ovs_phase); end
        end
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 1'b0, 16'd5, 4'd0, 1'b0);
            exp = (k == 3);
            checks++;
            if (tick_ovs !== exp) begin errors++; $display("[TB] FAIL hold_resume_tick step %0d got %b want %b", k, tick_ovs, exp); end
        end
        checks++; if (ovs_phase !== 4'd3) begin errors++; $display("[TB] FAIL hold_resume_phase got %0d want 3", ovs_phase); end
    endtask

    // A pending load of 9 is in flight when reset hits; the default 27-clock periods must return.
    task automatic test_mid_reset();
        logic exp;
        applyStimulus(1'b1, 1'b0, 16'd5, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd5, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'd9, 4'd0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'd9, 4'd0, 1'b0);
        reset = 1'b0;
        checks++; if (tick_ovs !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tick got %b want 0", tick_ovs); end
        checks++; if (ovs_phase !== 4'd0) begin errors++; $display("[TB] FAIL midrst_phase got %0d want 0", ovs_phase); end
        for (int k = 1; k <= 54; k++) begin
            applyStimulus(1'b1, 1'b0, 16'd9, 4'd0, 1'b0);
            exp = (k == 27) || (k == 54);
            checks++;
            if (tick_ovs !== exp) begin errors++; $display("[TB] FAIL midrst_tick step %0d got %b want %b", k, tick_ovs, exp); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        div_int    = 16'd0;
        div_frac   = 4'd0;
        div_load   = 1'b0;
        sync_clear = 1'b0;
        test_reset();
        test_integer_div();
        test_fractional_div();
        test_min_divisor();
        test_reload();
        test_sync_clear();
        test_enable_hold();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
